// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial word transmitter.
package serial_tx_pkg;

    // Frame sequencer states: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_N            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // Counter width for a 0..range-1 count; never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags
// the last cycle of each period with tick. Held at zero while idle so a new
// frame always starts with a full-length first bit.
module serial_bit_timer
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int            TW   = cnt_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    assign tick = run && (timer_q == LAST);

    // Advance within the period, wrap on tick, park at zero when not running.
    always_comb begin
        timer_d = timer_q;
        if (!run || tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Timer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter. Each accepted word is presented one
// bit at a time on data, each bit held for CLKS_PER_BIT cycles, with enable
// marking the last cycle of every bit as the capture point for a downstream
// flop. frame_done pulses in the idle cycle that follows the final bit, so a
// word held on the input is taken in that same cycle.
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int N            = DEFAULT_N,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MSB_FIRST    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         data,
    output logic         enable,
    output logic         busy,
    output logic         frame_done
);

    localparam int               CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    state_e             state_q;
    state_e             state_d;
    logic [N-1:0]       shreg_q;
    logic [N-1:0]       shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   bit_cnt_d;
    logic               done_q;
    logic               done_d;

    logic               shifting;
    logic               accept;
    logic               tick;
    logic               last_bit;
    logic               head_bit;

    assign shifting = (state_q == SHIFT);
    assign accept   = in_valid && (state_q == IDLE);
    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign head_bit = (MSB_FIRST != 0) ? shreg_q[N-1] : shreg_q[0];

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .run   (shifting),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on acceptance, return to idle after the last bit's period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)         state_d = SHIFT;
            SHIFT:   if (tick && last_bit) state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift and count on each bit strobe.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = shifting && tick && last_bit;
        if (accept) begin
            shreg_d   = in_data;
            bit_cnt_d = '0;
        end else if (shifting && tick) begin
            shreg_d   = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end
    end

    // Datapath registers; the word is copied in, so later in_data changes are invisible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        in_ready   = (state_q == IDLE);
        busy       = shifting;
        data       = shifting ? head_bit : 1'b0;
        enable     = tick;
        frame_done = done_q;
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: three instances (default MSB-first, LSB-first,
// one clock per bit) share clock and reset. Stimulus pushes the expected
// capture events (bit value and cycle of each enable, then the frame_done
// cycle) into a per-instance queue; monitors pop and compare on every
// enable or frame_done seen at the falling edge.
module tb_serial_word_tx;

    typedef struct packed {
        logic        done;
        logic        bitv;
        logic [31:0] cyc;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data0, in_data1, in_data2;
    logic       in_valid0, in_valid1, in_valid2;
    logic       rdy0, rdy1, rdy2;
    logic       d0, d1, d2;
    logic       en0, en1, en2;
    logic       bsy0, bsy1, bsy2;
    logic       fd0, fd1, fd2;

    int    cyc   = 0;
    int    ntot  = 0;
    int    npass = 0;
    item_t q0[$];
    item_t q1[$];
    item_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_word_tx #(.N(8), .CLKS_PER_BIT(4), .MSB_FIRST(1)) u0 (
        .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(rdy0), .data(d0), .enable(en0), .busy(bsy0), .frame_done(fd0));

    serial_word_tx #(.N(8), .CLKS_PER_BIT(4), .MSB_FIRST(0)) u1 (
        .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(rdy1), .data(d1), .enable(en1), .busy(bsy1), .frame_done(fd1));

    serial_word_tx #(.N(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) u2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(rdy2), .data(d2), .enable(en2), .busy(bsy2), .frame_done(fd2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_it(input int inst, input item_t it);
        case (inst)
            0:       q0.push_back(it);
            1:       q1.push_back(it);
            default: q2.push_back(it);
        endcase
    endtask

    // Expected events for a word accepted on edge a: bit k strobed at
    // cycle a-1+cpb*(k+1), frame_done at cycle a+8*cpb.
    task automatic push_frame(input int inst, input logic [7:0] w, input int a,
                              input int cpb, input bit msb);
        item_t it;
        for (int k = 0; k < 8; k++) begin
            it.done = 1'b0;
            it.bitv = msb ? w[7-k] : w[k];
            it.cyc  = 32'(a - 1 + cpb * (k + 1));
            push_it(inst, it);
        end
        it.done = 1'b1;
        it.bitv = 1'b0;
        it.cyc  = 32'(a + 8 * cpb);
        push_it(inst, it);
    endtask

    task automatic mon(input int inst, input logic en, input logic fd, input logic d);
        item_t it;
        int    sz;
        case (inst)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            ntot++;
            $display("FAIL u%0d_unexpected: got enable=%0b frame_done=%0b at cycle %0d, required no event",
                     inst, en, fd, cyc);
            return;
        end
        case (inst)
            0:       it = q0.pop_front();
            1:       it = q1.pop_front();
            default: it = q2.pop_front();
        endcase
        chk($sformatf("u%0d_kind{en,fd}", inst), 32'({en, fd}), it.done ? 32'd1 : 32'd2);
        chk($sformatf("u%0d_cycle", inst), 32'(cyc), it.cyc);
        if (!it.done) chk($sformatf("u%0d_bit", inst), 32'(d), 32'(it.bitv));
    endtask

    always @(negedge clk) if (en0 || fd0) mon(0, en0, fd0, d0);
    always @(negedge clk) if (en1 || fd1) mon(1, en1, fd1, d1);
    always @(negedge clk) if (en2 || fd2) mon(2, en2, fd2, d2);

    // Called just after a rising edge; returns just after edge n.
    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, "_in_ready"},   32'(rdy0), 32'd1);
        chk({tag, "_busy"},       32'(bsy0), 32'd0);
        chk({tag, "_data"},       32'(d0),   32'd0);
        chk({tag, "_enable"},     32'(en0),  32'd0);
        chk({tag, "_frame_done"}, 32'(fd0),  32'd0);
    endtask

    int c;

    initial begin
        reset     = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
        in_data0  = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00;
        #1;
        reset     = 1'b0;
        in_valid0 = 1'b1; in_valid1 = 1'b1; in_valid2 = 1'b1;
        in_data0  = 8'hA5; in_data1 = 8'hA5; in_data2 = 8'hA5;

        // Reset held with in_valid high: nothing may be accepted.
        repeat (3) begin
            @(negedge clk);
            chk_idle0("rst");
            chk("rst_u1_busy", 32'(bsy1), 32'd0);
            chk("rst_u2_busy", 32'(bsy2), 32'd0);
        end
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(bsy0), 32'd0);
        chk("post_rst_in_ready", 32'(rdy0), 32'd1);

        // 0xA5 then held 0x3C on u0; 0x01 LSB-first on u1; 0xFF,0x00 at 1 clk/bit on u2.
        c = cyc;
        in_valid0 = 1'b1; in_data0 = 8'hA5; push_frame(0, 8'hA5, c + 1, 4, 1'b1);
        in_valid1 = 1'b1; in_data1 = 8'h01; push_frame(1, 8'h01, c + 1, 4, 1'b0);
        in_valid2 = 1'b1; in_data2 = 8'hFF; push_frame(2, 8'hFF, c + 1, 1, 1'b1);
        wait_to(c + 1);
        in_data0  = 8'h3C; push_frame(0, 8'h3C, c + 34, 4, 1'b1);
        in_valid1 = 1'b0;  in_data1 = 8'hFF;
        in_data2  = 8'h00; push_frame(2, 8'h00, c + 10, 1, 1'b1);
        wait_to(c + 10);
        in_valid2 = 1'b0; in_data2 = 8'h55;
        @(negedge clk);
        chk("busy_in_ready", 32'(rdy0), 32'd0);
        chk("busy_busy",     32'(bsy0), 32'd1);
        wait_to(c + 34);
        in_valid0 = 1'b0; in_data0 = 8'h00;
        wait_to(c + 50);
        in_data0 = 8'hFF;
        wait_to(c + 70);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        // Abort 0xA5 after its third strobe.
        c = cyc;
        in_valid0 = 1'b1; in_data0 = 8'hA5; push_frame(0, 8'hA5, c + 1, 4, 1'b1);
        wait_to(c + 1);
        in_valid0 = 1'b0;
        wait_to(c + 13);
        #2;
        reset = 1'b0;
        #1;
        chk_idle0("abort");
        chk("abort_pending_events", 32'(q0.size()), 32'd6);
        q0.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        c = cyc;
        wait_to(c + 5);

        // First word after release goes out whole.
        c = cyc;
        in_valid0 = 1'b1; in_data0 = 8'h81; push_frame(0, 8'h81, c + 1, 4, 1'b1);
        wait_to(c + 1);
        in_valid0 = 1'b0;
        wait_to(c + 40);
        chk("q0_final", 32'(q0.size()), 32'd0);
        chk("q1_final", 32'(q1.size()), 32'd0);
        chk("q2_final", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
